// File: rtl/tree_node_sequencer.sv
// Supervises NUM_CHILDREN children via start/done pulses, in parallel or index order, with optional per-launch timeout.
// Child pulse one cycle after accepted start, done_o one cycle after last child clears; no backpressure, all outputs registered.
module tree_node_sequencer #(
    parameter int NUM_CHILDREN = 5,
    parameter int TIMEOUT_W    = 16,
    parameter int IDX_W        = (NUM_CHILDREN > 1) ? $clog2(NUM_CHILDREN) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    mode_i,
    input  logic [TIMEOUT_W-1:0]    timeout_i,
    output logic [NUM_CHILDREN-1:0] child_start_o,
    input  logic [NUM_CHILDREN-1:0] child_done_i,
    output logic                    busy_o,
    output logic [IDX_W-1:0]        cur_idx_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic [NUM_CHILDREN-1:0] err_mask_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;

    logic                    r_mode;
    logic                    w_mode_nxt;
    logic [TIMEOUT_W-1:0]    r_tmo;
    logic [TIMEOUT_W-1:0]    w_tmo_nxt;
    logic [TIMEOUT_W-1:0]    r_cnt;
    logic [TIMEOUT_W-1:0]    w_cnt_nxt;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_idx_nxt;
    logic [NUM_CHILDREN-1:0] r_pend;
    logic [NUM_CHILDREN-1:0] w_pend_nxt;
    logic [NUM_CHILDREN-1:0] r_err;
    logic [NUM_CHILDREN-1:0] w_err_nxt;

    logic [NUM_CHILDREN-1:0] r_child_start;
    logic [NUM_CHILDREN-1:0] w_child_start_nxt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_err_any;
    logic [NUM_CHILDREN-1:0] r_err_mask;
    logic [NUM_CHILDREN-1:0] w_err_mask_nxt;

    logic [NUM_CHILDREN-1:0] w_pend_left;
    logic                    w_tmo_hit;
    logic                    w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_mode_nxt     = r_mode;
        w_tmo_nxt      = r_tmo;
        w_cnt_nxt      = r_cnt;
        w_idx_nxt      = r_idx;
        w_pend_nxt     = r_pend;
        w_err_nxt      = r_err;
        w_err_mask_nxt = r_err_mask;

        // A done in the same cycle as the timeout clears its child before the timeout samples pending.
        w_pend_left = r_pend & ~child_done_i;
        w_tmo_hit   = (r_tmo != '0) && (r_cnt == r_tmo) && (w_pend_left != '0);
        w_last      = (int'(r_idx) == NUM_CHILDREN - 1);

        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_mode_nxt     = mode_i;
                    w_tmo_nxt      = timeout_i;
                    w_cnt_nxt      = '0;
                    w_idx_nxt      = '0;
                    w_pend_nxt     = '0;
                    w_err_nxt      = '0;
                    w_err_mask_nxt = '0;
                    w_state_nxt    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // r_cnt counts cycles since the launch cycle, so WAIT cycle S+k sees k.
                w_pend_nxt  = r_child_start;
                w_cnt_nxt   = TIMEOUT_W'(1);
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + TIMEOUT_W'(1);
                if (w_tmo_hit) begin
                    w_err_nxt  = r_err | w_pend_left;
                    w_pend_nxt = '0;
                end else begin
                    w_pend_nxt = w_pend_left;
                end
                if (w_tmo_hit || (w_pend_left == '0)) begin
                    if (!r_mode || w_last) begin
                        w_err_mask_nxt = w_err_nxt;
                        w_state_nxt    = S_FINISH;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_LAUNCH;
                    end
                end
            end
            S_FINISH: begin
                w_idx_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_child_start_nxt = '0;
        if (w_state_nxt == S_LAUNCH) begin
            if (w_mode_nxt) begin
                for (int k = 0; k < NUM_CHILDREN; k++) begin
                    w_child_start_nxt[k] = (w_idx_nxt == IDX_W'(k));
                end
            end else begin
                w_child_start_nxt = '1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode        <= 1'b0;
            r_tmo         <= '0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_pend        <= '0;
            r_err         <= '0;
            r_child_start <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_any     <= 1'b0;
            r_err_mask    <= '0;
        end else begin
            r_mode        <= w_mode_nxt;
            r_tmo         <= w_tmo_nxt;
            r_cnt         <= w_cnt_nxt;
            r_idx         <= w_idx_nxt;
            r_pend        <= w_pend_nxt;
            r_err         <= w_err_nxt;
            r_child_start <= w_child_start_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_done        <= (w_state_nxt == S_FINISH);
            r_err_any     <= |w_err_mask_nxt;
            r_err_mask    <= w_err_mask_nxt;
        end
    end

    assign child_start_o = r_child_start;
    assign busy_o        = r_busy;
    assign cur_idx_o     = r_idx;
    assign done_o        = r_done;
    assign err_o         = r_err_any;
    assign err_mask_o    = r_err_mask;

endmodule

// File: tb/tb_tree_node_sequencer.sv
// Bench for tree_node_sequencer: table of scenarios with child responders, pulse and completion scoreboards.
`timescale 1ns/1ps
module tb_tree_node_sequencer;
    localparam int N  = 5;
    localparam int TW = 16;
    localparam int IW = 3;
    localparam int NV = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [TW-1:0] timeout_i = '0;
    logic [N-1:0]  child_done_i = '0;
    logic [N-1:0]  child_start_o;
    logic          busy_o;
    logic [IW-1:0] cur_idx_o;
    logic          done_o;
    logic          err_o;
    logic [N-1:0]  err_mask_o;

    always #5 clk = ~clk;

    tree_node_sequencer #(.NUM_CHILDREN(N), .TIMEOUT_W(TW), .IDX_W(IW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .mode_i       (mode_i),
        .timeout_i    (timeout_i),
        .child_start_o(child_start_o),
        .child_done_i (child_done_i),
        .busy_o       (busy_o),
        .cur_idx_o    (cur_idx_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .err_mask_o   (err_mask_o)
    );

    // dly[k]: cycles from child k's pulse to its done pulse, 0 = never answers.
    typedef struct packed {
        logic             mode;
        logic [15:0]      tmo;
        logic [N-1:0][7:0] dly;
        logic [N-1:0]     mask;
        int               lat;
        logic             noise;
    } vec_t;

    typedef struct packed {
        logic [N-1:0] vec;
        int           idx;
        int           cyc;
    } pulse_t;

    typedef struct packed {
        logic [N-1:0] mask;
        int           cyc;
    } exp_t;

    vec_t   vt[NV];
    pulse_t pq[$];
    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    function automatic vec_t mk(input logic m, input int t, input int d0, input int d1, input int d2,
                                input int d3, input int d4, input logic [N-1:0] mask, input int lat,
                                input logic noise);
        vec_t v;
        v.mode   = m;
        v.tmo    = 16'(t);
        v.dly[0] = 8'(d0);
        v.dly[1] = 8'(d1);
        v.dly[2] = 8'(d2);
        v.dly[3] = 8'(d3);
        v.dly[4] = 8'(d4);
        v.mask   = mask;
        v.lat    = lat;
        v.noise  = noise;
        return v;
    endfunction

    // Cycles a launch occupies after its pulse: the done delay, or the timeout if it expires first.
    function automatic int eff(input int d, input int t);
        if (d == 0) return t;
        if (t != 0 && d > t) return t;
        return d;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_start"}, child_start_o, '0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_idx"}, cur_idx_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_mask"}, err_mask_o, '0);
    endtask

    task automatic run_vec(input vec_t v, input int rst_idx);
        int           due[N];
        int           t0;
        int           p;
        bit           fin;
        pulse_t       pe;
        exp_t         ex;
        exp_t         got;
        logic [N-1:0] one;
        one = 1;
        for (int k = 0; k < N; k++) due[k] = -1;
        tick();
        t0           = cyc;
        start_i      = 1'b1;
        mode_i       = v.mode;
        timeout_i    = v.tmo;
        child_done_i = '0;
        ex.mask = v.mask;
        ex.cyc  = t0 + v.lat;
        sb.push_back(ex);
        if (!v.mode) begin
            pe.vec = '1; pe.idx = 0; pe.cyc = t0 + 1;
            pq.push_back(pe);
        end else begin
            p = t0 + 1;
            for (int k = 0; k < N; k++) begin
                pe.vec = one << k; pe.idx = k; pe.cyc = p;
                pq.push_back(pe);
                p = p + eff(int'(v.dly[k]), int'(v.tmo)) + 1;
            end
        end
        fin = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            tick();
            start_i   = 1'b0;
            mode_i    = ~v.mode;
            timeout_i = 16'd1;
            chk("busy", busy_o, (cyc <= ex.cyc));
            if (cyc == t0 + 1) begin
                chk("mask_clr", err_mask_o, '0);
                chk("err_clr", err_o, 0);
            end
            if (child_start_o != '0) begin
                if (pq.size() == 0) begin
                    chk("pulse_extra", child_start_o, '0);
                end else begin
                    pe = pq.pop_front();
                    chk("pulse_vec", child_start_o, pe.vec);
                    chk("pulse_cyc", cyc, pe.cyc);
                    chk("cur_idx", cur_idx_o, pe.idx);
                end
                for (int k = 0; k < N; k++)
                    if (child_start_o[k] && v.dly[k] != 0) due[k] = cyc + int'(v.dly[k]);
            end
            if (rst_idx >= 0 && int'(cur_idx_o) == rst_idx && child_start_o == '0 && busy_o) begin
                #2 rst_n = 1'b0;
                #1 chk_quiet("rst_async");
                child_done_i = '0;
                sb.delete();
                pq.delete();
                return;
            end
            if (done_o) begin
                if (sb.size() == 0) begin
                    chk("done_extra", done_o, 0);
                end else begin
                    got = sb.pop_front();
                    chk("done_cyc", cyc, got.cyc);
                    chk("err_mask", err_mask_o, got.mask);
                    chk("err_o", err_o, |got.mask);
                end
                fin = 1'b1;
            end
            for (int k = 0; k < N; k++) child_done_i[k] = (due[k] == cyc);
            if (v.noise) begin
                if (child_start_o != '0) child_done_i = '1;
                for (int k = 0; k < N; k++) if (due[k] == cyc - 1) child_done_i[k] = 1'b1;
                if (busy_o && !done_o) start_i = 1'b1;
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
        child_done_i = '0;
        start_i      = 1'b0;
        repeat (2) begin
            tick();
            chk("idle_busy", busy_o, 0);
            chk("idle_done", done_o, 0);
            chk("idle_start", child_start_o, '0);
            chk("mask_hold", err_mask_o, v.mask);
        end
        chk("pulse_missing", pq.size(), 0);
        pq.delete();
        sb.delete();
    endtask

    initial begin
        vt[0] = mk(1'b0, 0,  2, 2, 2, 2, 2, 5'b00000,  4, 1'b0);
        vt[1] = mk(1'b1, 10, 2, 2, 2, 2, 2, 5'b00000, 16, 1'b0);
        vt[2] = mk(1'b1, 4,  1, 1, 0, 1, 1, 5'b00100, 14, 1'b0);
        vt[3] = mk(1'b0, 6,  1, 6, 3, 2, 0, 5'b10000,  8, 1'b0);
        vt[4] = mk(1'b0, 0,  1, 1, 1, 1, 1, 5'b00000,  3, 1'b0);
        vt[5] = mk(1'b1, 0,  1, 1, 1, 1, 1, 5'b00000, 11, 1'b0);
        vt[6] = mk(1'b0, 3,  0, 0, 0, 0, 0, 5'b11111,  5, 1'b0);
        vt[7] = mk(1'b1, 2,  3, 2, 0, 1, 5, 5'b10101, 15, 1'b0);
        vt[8] = mk(1'b0, 0,  2, 2, 2, 2, 2, 5'b00000,  4, 1'b1);
        vt[9] = mk(1'b1, 4,  1, 1, 0, 1, 1, 5'b00100, 14, 1'b1);

        rst_n = 1'b0;
        repeat (2) tick();
        chk_quiet("reset");
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) run_vec(vt[i], -1);

        // Abort a sequential run while child 3 is outstanding, then restart from scratch.
        run_vec(vt[1], 3);
        tick();
        chk_quiet("rst_hold");
        rst_n = 1'b1;
        run_vec(vt[1], -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tree_node_sequencer.md
# tree_node_sequencer

Parametrised hierarchy node that launches and supervises NUM_CHILDREN child sub-blocks through a start/done handshake. One start request fans out to all children at once (parallel mode) or one child at a time in index order (sequential mode), with an optional per-launch timeout. The node reports a single completion pulse and a per-child error mask, so nodes can be cascaded into arbitrarily deep, arbitrarily wide instance trees.

## Interface
- NUM_CHILDREN, 5, number of supervised children (1..64)
- TIMEOUT_W, 16, width of the timeout value and cycle counter
- IDX_W, $clog2(NUM_CHILDREN) (min 1), width of the child index

- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  start request; sampled in IDLE only
- mode_i  input  1  0 = parallel, 1 = sequential; latched on accepted start
- timeout_i  input  TIMEOUT_W  cycles allowed per launch; 0 = no timeout; latched on accepted start
- child_start_o  output  NUM_CHILDREN  one-cycle launch pulse per child
- child_done_i  input  NUM_CHILDREN  one-cycle completion pulse per child
- busy_o  output  1  operation in progress
- cur_idx_o  output  IDX_W  child currently launched (sequential); 0 in parallel/idle
- done_o  output  1  one-cycle completion pulse
- err_o  output  1  OR of err_mask_o; valid from done_o, held until next accepted start
- err_mask_o  output  NUM_CHILDREN  bit k set = child k timed out; held until next accepted start

## Operation
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE: start_i=1 -> latch mode_i, timeout_i; clear err_mask, pending, counter; go LAUNCH. start_i in any other state ignored.
- LAUNCH (one cycle): parallel: child_start_o = all ones, pending = all ones. Sequential: child_start_o = one-hot(cur_idx), pending = that bit. Counter reset to 0. Go WAIT.
- WAIT: counter increments each cycle (saturating at all ones). child_done_i[k] clears pending[k] only if pending[k]=1; done on non-pending child ignored.
- Timeout (timeout value != 0): when counter reaches timeout value with pending != 0, err_mask |= pending, pending cleared.
- Done and timeout in same cycle for same child: done wins, no error bit.
- pending becomes 0: parallel -> FINISH. Sequential -> if cur_idx == NUM_CHILDREN-1 go FINISH, else cur_idx+1, go LAUNCH.
- FINISH (one cycle): done_o=1, err_o/err_mask_o reflect final mask; go IDLE.
- Reset (any time, including mid-operation): state IDLE, all outputs 0, cur_idx 0, counter 0, pending 0; children receive no further pulses.

## Timing
- start_i accepted at edge T -> child_start_o pulse in cycle T+1 (registered outputs only).
- busy_o high from the LAUNCH cycle through the FINISH cycle inclusive; low in IDLE.
- Launch at cycle S: done accepted in cycles S+1..S+timeout; child_done_i in cycle S ignored. No done by S+timeout -> timeout recorded at that edge.
- Sequential: child k done at cycle t -> child_start_o[k+1] at t+1; last child done at t -> done_o at t+1. Timeout behaves identically to a done for advancing.
- Parallel: last pending cleared at t -> done_o at t+1.
- Minimum operation: parallel 3 cycles start-to-done_o for all children done at S+1; sequential 2*NUM_CHILDREN+1.
- New start_i may be accepted in the cycle after done_o (IDLE).
- err_mask_o/err_o update only in the FINISH cycle and on accepted start (cleared); stable otherwise.

## Test plan
- Parallel, N=5, timeout=0: start at T; all children done at T+3 -> child_start_o=5'b11111 at T+1, done_o at T+4, err_mask_o=0, busy_o high T+1..T+4.
- Sequential, N=5, timeout=10: each child done 2 cycles after its pulse -> pulses on bits 0..4 at T+1,T+4,T+7,T+10,T+13; done_o at T+16; cur_idx_o tracks 0..4.
- Sequential timeout: child 2 never responds, timeout=4 -> child 3 pulse exactly 5 cycles after child 2 pulse; final err_mask_o=5'b00100, err_o=1.
- Parallel timeout with edge: timeout=6, child 1 done at S+6, child 4 silent -> child 1 not flagged; err_mask_o=5'b10000, done_o at S+7.
- Ignored events: start_i pulsed while busy, child_done_i on already-done child, child_done_i in launch cycle -> no state change; operation completes as without them.
- Reset mid-WAIT (sequential, cur_idx=3): assert rst_n=0 asynchronously -> all outputs 0 immediately; after release, new start restarts at child 0 with cleared mask.
